text_console: RTL and testbench
===============================

// Module: text_console
// PURPOSE
// - Writer side of the 80x25 text-mode video buffer. Accepts a byte stream of characters from the CPU/UART.
// - Writes char/attribute pairs into the 4K text RAM: char at {idx,0}, attr at {idx,1}, idx = row*80+col.
// - Maintains the linear cursor position consumed by the text video generator.
// - Handles CR, LF, BS and FF; performs hardware scroll and clear-screen.
// PARAMETERS
// - COLS          80     characters per row
// - ROWS          25     rows per screen
// - BLANK_CHAR    8'h20  character code used by fill/clear
// - DEFAULT_ATTR  8'h07  attribute used by the clear after reset
// PORTS
// - clk        in   1   system clock, single clock domain
// - reset      in   1   synchronous, active-high reset
// - in_data    in   8   byte to process
// - in_attr    in   8   attribute (bg[6:4], fg[3:0]); sampled with in_data
// - in_valid   in   1   in_data valid
// - in_ready   out  1   byte accepted on a cycle where in_valid & in_ready
// - mem_addr   out  12  text RAM byte address, shared by read and write
// - mem_wren   out  1   write strobe for mem_wdata at mem_addr
// - mem_wdata  out  8   write data
// - mem_rdata  in   8   read data; valid one cycle after mem_addr is presented
// - cursor     out  11  linear cursor index, 0..1999
// - busy       out  1   high during scroll or clear
// BEHAVIOUR
// - Reset: mem_wren=0, cursor=0, in_ready=0, busy=1.
//   - Starts a full clear with BLANK_CHAR/DEFAULT_ATTR.
//   - Asserting reset mid-operation aborts the current operation and restarts the clear.
// - Registered state: row[4:0], col[6:0], cur_attr[7:0]. cursor = row*COLS+col, registered.
// - FSM states: IDLE, PUT_CH, PUT_AT, SCR_RD, SCR_WR, FILL.
// - IDLE: in_ready=1. On acceptance, latch in_data/in_attr; in_ready falls next cycle.
//   - Printable (>=8'h20) -> PUT_CH.
//   - 8'h0D: col=0.
//   - 8'h08: col=col-1 if col>0, else no change.
//   - 8'h0A: if row<ROWS-1 then row+1, else -> SCR_RD.
//   - 8'h0C: row=col=0, -> FILL over 0..3999.
//   - Other codes <8'h20: ignored.
//   - CR/BS/ignored codes: in_ready returns 1 cycle after acceptance.
// - Printable byte timing (accept at cycle N):
//   - N+1 PUT_CH: write {idx,0} <= char.
//   - N+2 PUT_AT: write {idx,1} <= attr.
//   - Then advance the cursor:
//     - col<COLS-1: col+1.
//     - else col=0 and row+1.
//     - If row was ROWS-1, -> SCR_RD with col=0 instead.
//   - in_ready=1 at N+3 when no scroll is needed.
// - Scroll (row stays ROWS-1):
//   - For src=160..3999, per byte:
//     - SCR_RD: mem_addr=src.
//     - SCR_WR: mem_addr=src-160, mem_wren=1, wdata=mem_rdata.
//   - Then FILL 3840..3999 with BLANK_CHAR at even addresses and cur_attr at odd addresses.
//   - Total 7680+160 cycles.
// - FILL: one byte per cycle, ascending; even = BLANK_CHAR, odd = attribute. Back to IDLE after last address.
// - busy=1 in SCR_RD/SCR_WR/FILL; in_ready=0 whenever busy or in PUT_*.
// - mem_wren=1 only in PUT_CH, PUT_AT, SCR_WR and FILL. Never writes addresses >=4000.
// - Address arithmetic is 12-bit unsigned; idx = row*80+col is computed in 11 bits with no wrap.
// STRUCTURE
// - text_console_pkg: COLS, ROWS, SCREEN_BYTES=4000, ROW_BYTES=160, codes CR/LF/BS/FF, state encoding.
// - Sub-module text_console_seq: start/end address counter with done flag, shared by the scroll copy and FILL.
// - Top level holds the FSM, cursor registers and mem port muxing.
// TESTING
// - Reset release -> 4000 writes: addr 0=20h, 1=07h ... 3999=07h; then in_ready=1, cursor=0.
// - Byte 41h with in_attr 1Fh at cursor 0 -> writes (0,41h), (1,1Fh); cursor=1; in_ready back 3 cycles after accept.
// - 80 printable bytes from cursor 0 -> last write at 158/159; cursor=80 (row1,col0). Then 0Dh, 08h -> cursor stays 80.
// - Cursor 1999, byte 42h -> writes 3998/3999; scroll: RAM[0..3839] = old RAM[160..3999], RAM[3840..3999] = 20h/attr; cursor=1920.
// - Cursor 1930 and 0Ah -> scroll, cursor=1930. 0Ch -> full fill, cursor=0, busy for 4000 cycles.
// - Reset pulsed mid-scroll -> next cycle mem_wren=0, cursor=0; full clear runs; the scroll never resumes.

Source files
------------

// File: rtl/text_console_pkg.sv
// ============================================================================
// Module  : text_console_pkg
// Brief   : Shared constants, control codes and state encoding for text_console.
// Revision: 1.0
// ============================================================================
`default_nettype none

package text_console_pkg;

    localparam int COLS         = 80;
    localparam int ROWS         = 25;
    localparam int SCREEN_BYTES = 4000;
    localparam int ROW_BYTES    = 160;

    localparam logic [7:0] CODE_BS       = 8'h08;
    localparam logic [7:0] CODE_LF       = 8'h0A;
    localparam logic [7:0] CODE_FF       = 8'h0C;
    localparam logic [7:0] CODE_CR       = 8'h0D;
    localparam logic [7:0] PRINTABLE_MIN = 8'h20;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_PUT_CH = 3'd1,
        ST_PUT_AT = 3'd2,
        ST_SCR_RD = 3'd3,
        ST_SCR_WR = 3'd4,
        ST_FILL   = 3'd5
    } state_t;

endpackage

`default_nettype wire

// File: rtl/text_console_if.sv
// ============================================================================
// Module  : text_console_if
// Brief   : Byte-stream input, text RAM port and cursor/status of text_console.
// Revision: 1.0
// ============================================================================
`default_nettype none

interface text_console_if;

    logic [7:0]  in_data;
    logic [7:0]  in_attr;
    logic        in_valid;
    logic        in_ready;
    logic [11:0] mem_addr;
    logic        mem_wren;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata;
    logic [10:0] cursor;
    logic        busy;

    modport master (
        output in_data, in_attr, in_valid, mem_rdata,
        input  in_ready, mem_addr, mem_wren, mem_wdata, cursor, busy
    );

    modport slave (
        input  in_data, in_attr, in_valid, mem_rdata,
        output in_ready, mem_addr, mem_wren, mem_wdata, cursor, busy
    );

endinterface

`default_nettype wire

// File: rtl/text_console_seq.sv
// ============================================================================
// Module  : text_console_seq
// Brief   : Loadable ascending address counter with end-reached flag.
// Revision: 1.0
// ============================================================================
`default_nettype none

module text_console_seq
    import text_console_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        start_i,
    input  logic        step_i,
    input  logic [11:0] start_addr_i,
    input  logic [11:0] end_addr_i,
    output logic [11:0] addr_o,
    output logic        done_o
);

    logic [11:0] addr_q, addr_d;
    logic [11:0] end_q,  end_d;

    always_comb begin
        addr_d = addr_q;
        end_d  = end_q;
        if (start_i) begin
            addr_d = start_addr_i;
            end_d  = end_addr_i;
        end else if (step_i && !done_o) begin
            addr_d = addr_q + 12'd1;
        end
    end

    // Reset value describes the full-screen clear that follows every reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            addr_q <= 12'd0;
            end_q  <= 12'(SCREEN_BYTES - 1);
        end else begin
            addr_q <= addr_d;
            end_q  <= end_d;
        end
    end

    assign addr_o = addr_q;
    assign done_o = (addr_q == end_q);

endmodule

`default_nettype wire

// File: rtl/text_console.sv
// ============================================================================
// Module  : text_console
// Brief   : Byte-stream writer for the 80x25 text buffer with scroll and clear.
// Revision: 1.0
// ============================================================================
`default_nettype none

module text_console #(
    parameter int         COLS         = text_console_pkg::COLS,
    parameter int         ROWS         = text_console_pkg::ROWS,
    parameter logic [7:0] BLANK_CHAR   = 8'h20,
    parameter logic [7:0] DEFAULT_ATTR = 8'h07
) (
    input logic           clk,
    input logic           reset,
    text_console_if.slave bus
);

    import text_console_pkg::*;

    localparam logic [4:0]  LAST_ROW      = 5'(ROWS - 1);
    localparam logic [6:0]  LAST_COL      = 7'(COLS - 1);
    localparam logic [11:0] LAST_BYTE     = 12'(SCREEN_BYTES - 1);
    localparam logic [11:0] ROW_OFFSET    = 12'(ROW_BYTES);
    localparam logic [11:0] LAST_ROW_BASE = 12'(SCREEN_BYTES - ROW_BYTES);

    state_t      state_q, state_d;
    logic [4:0]  row_q, row_d;
    logic [6:0]  col_q, col_d;
    logic [10:0] cursor_q, cursor_d;
    logic [7:0]  char_q, char_d;
    logic [7:0]  attr_q, attr_d;

    logic        seq_start, seq_step, seq_done;
    logic [11:0] seq_start_addr, seq_end_addr, seq_addr;

    text_console_seq u_seq (
        .clk          (clk),
        .reset        (reset),
        .start_i      (seq_start),
        .step_i       (seq_step),
        .start_addr_i (seq_start_addr),
        .end_addr_i   (seq_end_addr),
        .addr_o       (seq_addr),
        .done_o       (seq_done)
    );

    always_comb begin
        state_d        = state_q;
        row_d          = row_q;
        col_d          = col_q;
        char_d         = char_q;
        attr_d         = attr_q;
        seq_start      = 1'b0;
        seq_step       = 1'b0;
        seq_start_addr = ROW_OFFSET;
        seq_end_addr   = LAST_BYTE;
        bus.in_ready   = 1'b0;
        bus.mem_addr   = 12'd0;
        bus.mem_wren   = 1'b0;
        bus.mem_wdata  = 8'h00;
        bus.busy       = 1'b0;

        case (state_q)
            ST_IDLE: begin
                bus.in_ready = 1'b1;
                if (bus.in_valid) begin
                    char_d = bus.in_data;
                    attr_d = bus.in_attr;
                    if (bus.in_data >= PRINTABLE_MIN) begin
                        state_d = ST_PUT_CH;
                    end else begin
                        case (bus.in_data)
                            CODE_CR: col_d = 7'd0;
                            CODE_BS: if (col_q != 7'd0) col_d = col_q - 7'd1;
                            CODE_LF: begin
                                if (row_q != LAST_ROW) begin
                                    row_d = row_q + 5'd1;
                                end else begin
                                    state_d   = ST_SCR_RD;
                                    seq_start = 1'b1;
                                end
                            end
                            CODE_FF: begin
                                row_d          = 5'd0;
                                col_d          = 7'd0;
                                state_d        = ST_FILL;
                                seq_start      = 1'b1;
                                seq_start_addr = 12'd0;
                            end
                            default: ;
                        endcase
                    end
                end
            end
            ST_PUT_CH: begin
                bus.mem_addr  = {cursor_q, 1'b0};
                bus.mem_wren  = 1'b1;
                bus.mem_wdata = char_q;
                state_d       = ST_PUT_AT;
            end
            ST_PUT_AT: begin
                bus.mem_addr  = {cursor_q, 1'b1};
                bus.mem_wren  = 1'b1;
                bus.mem_wdata = attr_q;
                state_d       = ST_IDLE;
                if (col_q != LAST_COL) begin
                    col_d = col_q + 7'd1;
                end else begin
                    col_d = 7'd0;
                    if (row_q == LAST_ROW) begin
                        state_d   = ST_SCR_RD;
                        seq_start = 1'b1;
                    end else begin
                        row_d = row_q + 5'd1;
                    end
                end
            end
            ST_SCR_RD: begin
                bus.busy     = 1'b1;
                bus.mem_addr = seq_addr;
                state_d      = ST_SCR_WR;
            end
            // Read data for seq_addr arrives now; copy it one row up.
            ST_SCR_WR: begin
                bus.busy      = 1'b1;
                bus.mem_addr  = seq_addr - ROW_OFFSET;
                bus.mem_wren  = 1'b1;
                bus.mem_wdata = bus.mem_rdata;
                if (seq_done) begin
                    seq_start      = 1'b1;
                    seq_start_addr = LAST_ROW_BASE;
                    state_d        = ST_FILL;
                end else begin
                    seq_step = 1'b1;
                    state_d  = ST_SCR_RD;
                end
            end
            ST_FILL: begin
                bus.busy      = 1'b1;
                bus.mem_addr  = seq_addr;
                bus.mem_wren  = 1'b1;
                bus.mem_wdata = seq_addr[0] ? attr_q : BLANK_CHAR;
                if (seq_done) state_d = ST_IDLE;
                else          seq_step = 1'b1;
            end
            default: state_d = ST_IDLE;
        endcase

        // Hold off writes and input while reset is asserted.
        if (reset) begin
            bus.in_ready = 1'b0;
            bus.mem_wren = 1'b0;
            bus.busy     = 1'b1;
        end
    end

    assign cursor_d = 11'(row_d) * 11'(COLS) + 11'(col_d);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_FILL;
            row_q    <= 5'd0;
            col_q    <= 7'd0;
            cursor_q <= 11'd0;
            char_q   <= BLANK_CHAR;
            attr_q   <= DEFAULT_ATTR;
        end else begin
            state_q  <= state_d;
            row_q    <= row_d;
            col_q    <= col_d;
            cursor_q <= cursor_d;
            char_q   <= char_d;
            attr_q   <= attr_d;
        end
    end

    assign bus.cursor = cursor_q;

endmodule

`default_nettype wire

// File: tb/tb_text_console.sv
// ============================================================================
// Module  : tb_text_console
// Brief   : Directed self-checking bench for text_console with a text RAM model.
// Revision: 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_text_console;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    logic [1:0] pre_mode = 2'd0;

    text_console_if bus();

    text_console dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    logic [7:0] ram [0:4095];
    int wr_count  = 0;
    int bad_addr  = 0;
    int checks    = 0;
    int passes    = 0;

    function automatic logic [7:0] pat(input int i);
        return 8'(i) + 8'(i / 256) * 8'd7 + 8'h3;
    endfunction

    // Synchronous RAM: one-cycle read latency; bench preload when pre_mode != 0.
    always @(posedge clk) begin
        if (pre_mode != 2'd0) begin
            for (int i = 0; i < 4096; i++)
                ram[i] <= (pre_mode == 2'd1) ? 8'hAA : pat(i);
        end else if (bus.mem_wren) begin
            ram[bus.mem_addr] <= bus.mem_wdata;
            wr_count <= wr_count + 1;
            if (bus.mem_addr >= 12'd4000) bad_addr <= bad_addr + 1;
        end
        bus.mem_rdata <= ram[bus.mem_addr];
    end

    task automatic preload(input logic [1:0] mode);
        pre_mode = mode;
        @(posedge clk); #1;
        pre_mode = 2'd0;
    endtask

    task automatic send(input logic [7:0] d, input logic [7:0] a);
        bus.in_data  = d;
        bus.in_attr  = a;
        bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_ready(input int budget, output int n);
        n = 0;
        while (n < budget) begin
            @(posedge clk); #1;
            n++;
            if (bus.in_ready) break;
        end
    endtask

    task automatic print_byte(input logic [7:0] d, input logic [7:0] a);
        int n;
        send(d, a);
        wait_ready(20, n);
    endtask

    function automatic int clear_errs(input logic [7:0] attr);
        int e = 0;
        for (int i = 0; i < 4000; i++)
            if (ram[i] !== ((i % 2 == 1) ? attr : 8'h20)) e++;
        return e;
    endfunction

    function automatic int scroll_errs(input logic [7:0] attr, input bit put, input logic [7:0] ch);
        int e = 0;
        logic [7:0] want;
        for (int j = 0; j < 4000; j++) begin
            if (j < 3840) begin
                if (put && j + 160 == 3998)      want = ch;
                else if (put && j + 160 == 3999) want = attr;
                else                             want = pat(j + 160);
            end else begin
                want = (j % 2 == 1) ? attr : 8'h20;
            end
            if (ram[j] !== want) e++;
        end
        return e;
    endfunction

    task automatic test_reset;
        int n, base, e;
        preload(2'd1);
        repeat (2) @(posedge clk);
        #1;
        checks++; if (bus.mem_wren !== 1'b0) $display("FAIL rst_wren: got %0h want 0", bus.mem_wren); else passes++;
        checks++; if (bus.cursor !== 11'd0) $display("FAIL rst_cursor: got %0d want 0", bus.cursor); else passes++;
        checks++; if (bus.in_ready !== 1'b0) $display("FAIL rst_ready: got %0h want 0", bus.in_ready); else passes++;
        checks++; if (bus.busy !== 1'b1) $display("FAIL rst_busy: got %0h want 1", bus.busy); else passes++;
        base = wr_count;
        reset = 1'b0;
        wait_ready(5000, n);
        e = clear_errs(8'h07);
        checks++; if (n !== 4000) $display("FAIL clr_cycles: got %0d want 4000", n); else passes++;
        checks++; if (wr_count - base !== 4000) $display("FAIL clr_writes: got %0d want 4000", wr_count - base); else passes++;
        checks++; if (e !== 0) $display("FAIL clr_content: got %0d bad bytes want 0", e); else passes++;
        checks++; if (ram[4000] !== 8'hAA) $display("FAIL clr_4000: got %0h want aa", ram[4000]); else passes++;
        checks++; if (bus.cursor !== 11'd0) $display("FAIL clr_cursor: got %0d want 0", bus.cursor); else passes++;
    endtask

    task automatic test_print;
        int n;
        send(8'h41, 8'h1F);
        checks++; if (bus.in_ready !== 1'b0) $display("FAIL put_ready_lo: got %0h want 0", bus.in_ready); else passes++;
        checks++; if ({bus.mem_wren, bus.mem_addr, bus.mem_wdata} !== {1'b1, 12'd0, 8'h41})
            $display("FAIL put_ch: got wren=%0h addr=%0d data=%0h want 1/0/41", bus.mem_wren, bus.mem_addr, bus.mem_wdata); else passes++;
        @(posedge clk); #1;
        checks++; if ({bus.mem_wren, bus.mem_addr, bus.mem_wdata} !== {1'b1, 12'd1, 8'h1F})
            $display("FAIL put_at: got wren=%0h addr=%0d data=%0h want 1/1/1f", bus.mem_wren, bus.mem_addr, bus.mem_wdata); else passes++;
        @(posedge clk); #1;
        checks++; if (bus.in_ready !== 1'b1) $display("FAIL put_ready_n3: got %0h want 1", bus.in_ready); else passes++;
        checks++; if (bus.cursor !== 11'd1) $display("FAIL put_cursor: got %0d want 1", bus.cursor); else passes++;
        checks++; if ({ram[0], ram[1]} !== 16'h411F) $display("FAIL put_ram: got %0h want 411f", {ram[0], ram[1]}); else passes++;
        n = 0;
    endtask

    task automatic test_row_and_controls;
        int base;
        send(8'h0D, 8'h07);
        checks++; if ({bus.in_ready, bus.cursor} !== {1'b1, 11'd0}) $display("FAIL cr_col0: got rdy=%0h cur=%0d want 1/0", bus.in_ready, bus.cursor); else passes++;
        for (int k = 0; k < 80; k++) print_byte(8'h41 + 8'(k % 26), 8'h2E);
        checks++; if (bus.cursor !== 11'd80) $display("FAIL row_cursor: got %0d want 80", bus.cursor); else passes++;
        checks++; if ({ram[158], ram[159]} !== 16'h422E) $display("FAIL row_last: got %0h want 422e", {ram[158], ram[159]}); else passes++;
        send(8'h0D, 8'h07);
        checks++; if ({bus.in_ready, bus.cursor} !== {1'b1, 11'd80}) $display("FAIL cr_row1: got rdy=%0h cur=%0d want 1/80", bus.in_ready, bus.cursor); else passes++;
        send(8'h08, 8'h07);
        checks++; if (bus.cursor !== 11'd80) $display("FAIL bs_col0: got %0d want 80", bus.cursor); else passes++;
        print_byte(8'h78, 8'h07);
        send(8'h08, 8'h07);
        checks++; if (bus.cursor !== 11'd80) $display("FAIL bs_back: got %0d want 80", bus.cursor); else passes++;
        base = wr_count;
        send(8'h01, 8'h07);
        repeat (3) @(posedge clk);
        #1;
        checks++; if ({bus.cursor, wr_count - base} !== {11'd80, 32'd0}) $display("FAIL ignore: got cur=%0d writes=%0d want 80/0", bus.cursor, wr_count - base); else passes++;
        send(8'h0A, 8'h07);
        checks++; if (bus.cursor !== 11'd160) $display("FAIL lf_row: got %0d want 160", bus.cursor); else passes++;
    endtask

    task automatic test_scroll_print;
        int n, base, e;
        for (int k = 0; k < 22; k++) send(8'h0A, 8'h07);
        checks++; if (bus.cursor !== 11'd1920) $display("FAIL lf_to_last: got %0d want 1920", bus.cursor); else passes++;
        for (int k = 0; k < 79; k++) print_byte(8'h7A, 8'h07);
        checks++; if (bus.cursor !== 11'd1999) $display("FAIL at_1999: got %0d want 1999", bus.cursor); else passes++;
        preload(2'd2);
        send(8'h42, 8'h3C);
        base = wr_count;
        wait_ready(9000, n);
        e = scroll_errs(8'h3C, 1'b1, 8'h42);
        checks++; if (n !== 7842) $display("FAIL scr_cycles: got %0d want 7842", n); else passes++;
        checks++; if (wr_count - base !== 4002) $display("FAIL scr_writes: got %0d want 4002", wr_count - base); else passes++;
        checks++; if (e !== 0) $display("FAIL scr_content: got %0d bad bytes want 0", e); else passes++;
        checks++; if (bus.cursor !== 11'd1920) $display("FAIL scr_cursor: got %0d want 1920", bus.cursor); else passes++;
    endtask

    task automatic test_lf_scroll_and_ff;
        int n, base, e;
        for (int k = 0; k < 10; k++) print_byte(8'h30 + 8'(k), 8'h07);
        preload(2'd2);
        send(8'h0A, 8'h5A);
        base = wr_count;
        checks++; if (bus.busy !== 1'b1) $display("FAIL lfs_busy: got %0h want 1", bus.busy); else passes++;
        wait_ready(9000, n);
        e = scroll_errs(8'h5A, 1'b0, 8'h00);
        checks++; if (n !== 7840) $display("FAIL lfs_cycles: got %0d want 7840", n); else passes++;
        checks++; if (wr_count - base !== 4000) $display("FAIL lfs_writes: got %0d want 4000", wr_count - base); else passes++;
        checks++; if (e !== 0) $display("FAIL lfs_content: got %0d bad bytes want 0", e); else passes++;
        checks++; if (bus.cursor !== 11'd1930) $display("FAIL lfs_cursor: got %0d want 1930", bus.cursor); else passes++;
        send(8'h0C, 8'h17);
        checks++; if ({bus.busy, bus.cursor} !== {1'b1, 11'd0}) $display("FAIL ff_start: got busy=%0h cur=%0d want 1/0", bus.busy, bus.cursor); else passes++;
        wait_ready(5000, n);
        e = clear_errs(8'h17);
        checks++; if (n !== 4000) $display("FAIL ff_cycles: got %0d want 4000", n); else passes++;
        checks++; if (e !== 0) $display("FAIL ff_content: got %0d bad bytes want 0", e); else passes++;
    endtask

    task automatic test_reset_mid_scroll;
        int n, base, e, after;
        for (int k = 0; k < 24; k++) send(8'h0A, 8'h07);
        send(8'h0A, 8'h66);
        repeat (100) @(posedge clk);
        #1;
        checks++; if (bus.busy !== 1'b1) $display("FAIL mid_busy: got %0h want 1", bus.busy); else passes++;
        reset = 1'b1;
        @(posedge clk); #1;
        checks++; if ({bus.mem_wren, bus.cursor, bus.in_ready} !== {1'b0, 11'd0, 1'b0})
            $display("FAIL mid_rst: got wren=%0h cur=%0d rdy=%0h want 0/0/0", bus.mem_wren, bus.cursor, bus.in_ready); else passes++;
        reset = 1'b0;
        base = wr_count;
        wait_ready(5000, n);
        e = clear_errs(8'h07);
        checks++; if (n !== 4000) $display("FAIL mid_cycles: got %0d want 4000", n); else passes++;
        checks++; if (e !== 0) $display("FAIL mid_content: got %0d bad bytes want 0", e); else passes++;
        after = wr_count;
        repeat (20) @(posedge clk);
        #1;
        checks++; if ({bus.in_ready, wr_count - after} !== {1'b1, 32'd0}) $display("FAIL mid_noresume: got rdy=%0h writes=%0d want 1/0", bus.in_ready, wr_count - after); else passes++;
        checks++; if ((wr_count - base) !== 4000) $display("FAIL mid_writes: got %0d want 4000", wr_count - base); else passes++;
        checks++; if (bad_addr !== 0) $display("FAIL addr_range: got %0d writes above 3999 want 0", bad_addr); else passes++;
    endtask

    initial begin
        bus.in_data  = 8'h00;
        bus.in_attr  = 8'h00;
        bus.in_valid = 1'b0;
        test_reset();
        test_print();
        test_row_and_controls();
        test_scroll_print();
        test_lf_scroll_and_ff();
        test_reset_mid_scroll();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

`default_nettype wire
